compress_sched: RTL

//  Sequences the 8-lane compress datapath across one 256-coefficient polynomial.

---
 rtl/compress_sched_if.sv | 40 ++++
 rtl/compress_sched.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/compress_sched_if.sv
// Handshake and bus bundle between the compress scheduler and its surroundings:
// the start/status handshake, the poly RAM read port, the compress datapath
// result lanes and the packed 32-bit output stream.
interface compress_sched_if;
    // Control / status
    logic        start;
    logic [3:0]  d;
    logic        busy;
    logic        done;
    logic        err;
    // Poly RAM read port
    logic        mem_re;
    logic [4:0]  mem_addr;
    // Compress datapath
    logic [3:0]  cmp_d;
    logic [7:0]  cmp_d1;
    logic [31:0] cmp_d4;
    logic [79:0] cmp_d10;
    // Output stream.
    // A word transfers on every rising edge where out_valid && out_ready.
    // Once out_valid rises, out_data/out_last hold until that transfer.
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    // Scheduler side
    modport master (
        input  start, d, cmp_d1, cmp_d4, cmp_d10, out_ready,
        output busy, done, err, mem_re, mem_addr, cmp_d,
               out_valid, out_data, out_last
    );

    // Environment side (controller, RAM, compress, packer)
    modport slave (
        output start, d, cmp_d1, cmp_d4, cmp_d10, out_ready,
        input  busy, done, err, mem_re, mem_addr, cmp_d,
               out_valid, out_data, out_last
    );
endinterface

// File: rtl/compress_sched.sv
// Compress scheduler: walks the 32 poly RAM words of one polynomial, tracks
// the two-cycle RAM + compress latency, selects the d=1/4/10 result lanes and
// packs them little-endian into a 32-bit valid/ready stream.
//
// Reads are throttled by a credit check so that everything already in flight
// plus the new chunk always fits in the pack buffer even if the consumer
// stalls, which makes overflow impossible by construction.
module compress_sched #(
    parameter int BUF_W  = 128,
    parameter int NWORDS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    compress_sched_if.master bus
);

    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int ADDR_W = $clog2(NWORDS + 1);
    localparam int CNT_W  = 7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Chunk width in bits per RAM word; also the number of output words.
    function automatic logic [CNT_W-1:0] chunk_len(input logic [3:0] dv);
        case (dv)
            4'd1:    chunk_len = CNT_W'(8);
            4'd4:    chunk_len = CNT_W'(32);
            4'd10:   chunk_len = CNT_W'(80);
            default: chunk_len = '0;
        endcase
    endfunction

    function automatic logic d_is_legal(input logic [3:0] dv);
        d_is_legal = (dv == 4'd1) || (dv == 4'd4) || (dv == 4'd10);
    endfunction

    // FSM and control registers
    state_t              state_q, state_d;
    logic [3:0]          d_q, d_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                mem_re_q, issue_d;
    logic                busy_q, done_q, err_q;

    // Datapath registers
    logic [1:0]          vld_q;
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]    words_q, words_d;

    // Combinational helpers
    logic                start_ok, start_bad;
    logic [CNT_W-1:0]    c_cur, c_nxt;
    logic                out_valid_w, hs, last_w;
    logic [BUF_W-1:0]    chunk_ext, base_buf;
    logic [FILL_W-1:0]   base_fill;
    logic [9:0]          need_d;

    assign start_ok  = (state_q == S_IDLE) && bus.start &&  d_is_legal(bus.d);
    assign start_bad = (state_q == S_IDLE) && bus.start && !d_is_legal(bus.d);

    assign c_cur       = chunk_len(d_q);
    assign out_valid_w = (fill_q >= FILL_W'(32));
    assign hs          = out_valid_w && bus.out_ready;
    assign last_w      = (words_q == (c_cur - CNT_W'(1)));

    // Pack buffer: shift out on handshake, then OR the arriving chunk in at the
    // post-shift fill level. Bits above fill are always zero, so the low word
    // cannot change while a stalled word is on the bus.
    always_comb begin
        chunk_ext = '0;
        case (d_q)
            4'd1:    chunk_ext[7:0]  = bus.cmp_d1;
            4'd4:    chunk_ext[31:0] = bus.cmp_d4;
            4'd10:   chunk_ext[79:0] = bus.cmp_d10;
            default: chunk_ext       = '0;
        endcase

        base_buf  = hs ? (buf_q >> 32) : buf_q;
        base_fill = hs ? (fill_q - FILL_W'(32)) : fill_q;

        buf_d   = base_buf;
        fill_d  = base_fill;
        words_d = hs ? (words_q + CNT_W'(1)) : words_q;

        if (vld_q[1]) begin
            buf_d  = base_buf | (chunk_ext << base_fill);
            fill_d = base_fill + FILL_W'(c_cur);
        end

        if (start_ok) begin
            buf_d   = '0;
            fill_d  = '0;
            words_d = '0;
        end
    end

    // Next state, latched depth, address and the read decision for the next
    // cycle. The read enable is registered, so the credit check is evaluated
    // on the values the registers will hold when the read is actually issued.
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        addr_d  = addr_q + ADDR_W'(mem_re_q);

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_RUN;
                    d_d     = bus.d;
                    addr_d  = '0;
                end
            end
            S_RUN: begin
                if (mem_re_q && (addr_q == ADDR_W'(NWORDS - 1)))
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (hs && last_w)
                    state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        c_nxt  = chunk_len(d_d);
        // Reads in flight next cycle are the one issued now and the one
        // issued last cycle; the chunk landing now is already in fill_d.
        need_d = 10'(fill_d) + 10'(c_nxt)
               + (mem_re_q ? 10'(c_nxt) : 10'd0)
               + (vld_q[0] ? 10'(c_nxt) : 10'd0);
        issue_d = (state_d == S_RUN) && (addr_d < ADDR_W'(NWORDS))
               && (need_d <= 10'(BUF_W));
    end

    // FSM state and registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            d_q      <= '0;
            addr_q   <= '0;
            mem_re_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            d_q      <= d_d;
            addr_q   <= addr_d;
            mem_re_q <= issue_d;
            busy_q   <= (state_d == S_RUN) || (state_d == S_DRAIN);
            done_q   <= (state_d == S_DONE);
            err_q    <= start_bad;
        end
    end

    // Read-latency tracking and pack buffer state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            buf_q   <= '0;
            fill_q  <= '0;
            words_q <= '0;
        end else begin
            vld_q   <= {vld_q[0], mem_re_q};
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            words_q <= words_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_addr  = addr_q[4:0];
    assign bus.cmp_d     = d_q;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = buf_q[31:0];
    assign bus.out_last  = out_valid_w && last_w;

endmodule
